// File: rtl/strobe_arbiter_if.sv
// Requester-side bundle of the strobe arbiter: level requests in, one-hot grant,
// single-cycle strobe enable, ack pulse and busy flag out.
interface strobe_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant;
  logic            strobe_en;
  logic [NREQ-1:0] ack;
  logic            busy;

  // The arbiter drives grant/strobe/ack/busy; requesters drive req.
  modport master (
    input  req,
    output grant,
    output strobe_en,
    output ack,
    output busy
  );

  modport slave (
    output req,
    input  grant,
    input  strobe_en,
    input  ack,
    input  busy
  );
endinterface

// File: rtl/strobe_arbiter.sv
// Round-robin owner of a shared edge-gated write strobe: grant, settle for HOLD+1
// cycles, one-cycle strobe_en, then ack the winner and rearbitrate.
module strobe_arbiter #(
  parameter int NREQ = 4,
  parameter int HOLD = 0
) (
  input  logic            clk,
  input  logic            rst,
  strobe_arbiter_if.master bus
);

  localparam int         IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [2:0] HOLD_CNT = 3'(HOLD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    FIRE  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t          state_q;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] ack_q;
  logic            strobe_q;
  logic            busy_q;
  logic [2:0]      cnt_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   win_q;

  logic            pick_vld_d;
  logic [IW-1:0]   pick_idx_d;

  // Search from base+1 upward with wrap; the lowest offset that is requesting wins,
  // so the previous winner (base itself) is tried last.
  function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] base);
    logic [IW:0] res;
    int          idx;
    res = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = int'(base) + i;
      idx = (idx >= NREQ) ? (idx - NREQ) : idx;
      res = r[idx] ? {1'b1, IW'(idx)} : res;
    end
    return res;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
    return NREQ'(1'b1) << i;
  endfunction

  // Round-robin candidate for the next grant, based on the last acknowledged owner.
  always_comb begin
    {pick_vld_d, pick_idx_d} = rr_pick(bus.req, ptr_q);
  end

  // Grant/strobe/ack sequencer; every output is a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      ack_q    <= '0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= 3'd0;
      ptr_q    <= IW'(NREQ - 1);
      win_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          strobe_q <= 1'b0;
          ack_q    <= '0;
          if (pick_vld_d) begin
            state_q <= SETUP;
            win_q   <= pick_idx_d;
            grant_q <= onehot(pick_idx_d);
            busy_q  <= 1'b1;
            cnt_q   <= HOLD_CNT;
          end else begin
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
        end
        SETUP: begin
          if (!bus.req[win_q]) begin
            // Owner withdrew before the strobe: abandon without touching the pointer.
            state_q <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == 3'd0) begin
            state_q  <= FIRE;
            strobe_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        FIRE: begin
          state_q  <= ACK;
          strobe_q <= 1'b0;
          ack_q    <= onehot(win_q);
          ptr_q    <= win_q;
        end
        ACK: begin
          ack_q <= '0;
          if (pick_vld_d) begin
            state_q <= SETUP;
            win_q   <= pick_idx_d;
            grant_q <= onehot(pick_idx_d);
            cnt_q   <= HOLD_CNT;
          end else begin
            state_q <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          grant_q  <= '0;
          ack_q    <= '0;
          strobe_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.ack       = ack_q;
  assign bus.strobe_en = strobe_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_strobe_arbiter.sv
// Directed bench for strobe_arbiter: three instances (HOLD 0/2/3), expected outputs
// queued per step and compared one time unit after the following rising edge.
module tb_strobe_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sel = 2'd0;
  logic [3:0] req_drv = 4'd0;

  strobe_arbiter_if #(.NREQ(4)) if0 ();
  strobe_arbiter_if #(.NREQ(4)) if2 ();
  strobe_arbiter_if #(.NREQ(4)) if3 ();

  strobe_arbiter #(.NREQ(4), .HOLD(0)) u_h0 (.clk(clk), .rst(rst), .bus(if0));
  strobe_arbiter #(.NREQ(4), .HOLD(2)) u_h2 (.clk(clk), .rst(rst), .bus(if2));
  strobe_arbiter #(.NREQ(4), .HOLD(3)) u_h3 (.clk(clk), .rst(rst), .bus(if3));

  always #5 clk = ~clk;

  assign if0.req = (sel == 2'd0) ? req_drv : 4'd0;
  assign if2.req = (sel == 2'd1) ? req_drv : 4'd0;
  assign if3.req = (sel == 2'd2) ? req_drv : 4'd0;

  logic [3:0] obs_grant, obs_ack;
  logic       obs_strobe, obs_busy;
  assign obs_grant  = (sel == 2'd0) ? if0.grant : (sel == 2'd1) ? if2.grant : if3.grant;
  assign obs_ack    = (sel == 2'd0) ? if0.ack : (sel == 2'd1) ? if2.ack : if3.ack;
  assign obs_strobe = (sel == 2'd0) ? if0.strobe_en : (sel == 2'd1) ? if2.strobe_en : if3.strobe_en;
  assign obs_busy   = (sel == 2'd0) ? if0.busy : (sel == 2'd1) ? if2.busy : if3.busy;

  typedef struct packed {
    logic [3:0] g;
    logic       s;
    logic [3:0] a;
    logic       b;
  } exp_t;

  exp_t  sb[$];
  int    n_pass  = 0;
  int    n_total = 0;
  int    step_no = 0;
  string phase   = "init";

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %b want %b", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".grant"}, obs_grant, e.g);
    chk({tag, ".strobe_en"}, {3'b000, obs_strobe}, {3'b000, e.s});
    chk({tag, ".ack"}, obs_ack, e.a);
    chk({tag, ".busy"}, {3'b000, obs_busy}, {3'b000, e.b});
  endtask

  // Drive req for the next edge, queue what the outputs must be after it, then compare.
  task automatic step(input logic [3:0] r, input logic [3:0] g, input logic s,
                      input logic [3:0] a, input logic b);
    exp_t e;
    e.g = g; e.s = s; e.a = a; e.b = b;
    req_drv = r;
    sb.push_back(e);
    @(posedge clk);
    #1;
    step_no++;
    chk_all($sformatf("%s[%0d]", phase, step_no), sb.pop_front());
  endtask

  task automatic do_reset();
    exp_t z;
    z = '0;
    @(negedge clk);
    req_drv = 4'd0;
    rst = 1'b1;
    #1;
    chk_all({phase, ".rst"}, z);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    exp_t z;
    z = '0;
    #12;
    phase = "reset";
    for (int k = 0; k < 3; k++) begin
      sel = 2'(k);
      #1;
      chk_all($sformatf("reset.dut%0d", k), z);
    end
    sel = 2'd0;
    @(negedge clk);
    rst = 1'b0;

    // Single request, HOLD=0.
    phase = "single"; step_no = 0;
    step(4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b1);
    step(4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b1);
    step(4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1);
    step(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);

    // All four requesting; each drops for one cycle after its ack.
    phase = "rr"; step_no = 0;
    do_reset();
    step(4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1);
    step(4'b1111, 4'b0001, 1'b1, 4'b0000, 1'b1);
    step(4'b1111, 4'b0001, 1'b0, 4'b0001, 1'b1);
    step(4'b1111, 4'b0010, 1'b0, 4'b0000, 1'b1);
    step(4'b1110, 4'b0010, 1'b1, 4'b0000, 1'b1);
    step(4'b1111, 4'b0010, 1'b0, 4'b0010, 1'b1);
    step(4'b1111, 4'b0100, 1'b0, 4'b0000, 1'b1);
    step(4'b1101, 4'b0100, 1'b1, 4'b0000, 1'b1);
    step(4'b1111, 4'b0100, 1'b0, 4'b0100, 1'b1);
    step(4'b1111, 4'b1000, 1'b0, 4'b0000, 1'b1);
    step(4'b1011, 4'b1000, 1'b1, 4'b0000, 1'b1);
    step(4'b1111, 4'b1000, 1'b0, 4'b1000, 1'b1);
    step(4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1);
    step(4'b0111, 4'b0001, 1'b1, 4'b0000, 1'b1);
    step(4'b0000, 4'b0001, 1'b0, 4'b0001, 1'b1);
    step(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);

    // HOLD=2 settle window.
    phase = "hold2"; step_no = 0;
    sel = 2'd1;
    step(4'b0100, 4'b0100, 1'b0, 4'b0000, 1'b1);
    step(4'b0100, 4'b0100, 1'b0, 4'b0000, 1'b1);
    step(4'b0100, 4'b0100, 1'b0, 4'b0000, 1'b1);
    step(4'b0100, 4'b0100, 1'b1, 4'b0000, 1'b1);
    step(4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b1);
    step(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);

    // HOLD=3 abort during settle, pointer must stay put.
    phase = "abort"; step_no = 0;
    sel = 2'd2;
    step(4'b0010, 4'b0010, 1'b0, 4'b0000, 1'b1);
    step(4'b0010, 4'b0010, 1'b0, 4'b0000, 1'b1);
    step(4'b0010, 4'b0010, 1'b0, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
    step(4'b0011, 4'b0001, 1'b0, 4'b0000, 1'b1);
    step(4'b0011, 4'b0001, 1'b0, 4'b0000, 1'b1);
    step(4'b0011, 4'b0001, 1'b0, 4'b0000, 1'b1);
    step(4'b0011, 4'b0001, 1'b0, 4'b0000, 1'b1);
    step(4'b0011, 4'b0001, 1'b1, 4'b0000, 1'b1);
    step(4'b0011, 4'b0001, 1'b0, 4'b0001, 1'b1);
    step(4'b0010, 4'b0010, 1'b0, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);

    // Asynchronous reset while strobe_en is high.
    phase = "arst"; step_no = 0;
    sel = 2'd0;
    step(4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1);
    step(4'b1000, 4'b1000, 1'b1, 4'b0000, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_all("arst.immediate", z);
    @(posedge clk);
    #1;
    chk_all("arst.held", z);
    #3;
    rst = 1'b0;
    step(4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1);
    step(4'b1000, 4'b1000, 1'b1, 4'b0000, 1'b1);
    step(4'b1000, 4'b1000, 1'b0, 4'b1000, 1'b1);
    step(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);

    // Direct ACK-to-SETUP handoff and previous-winner demotion.
    phase = "handoff"; step_no = 0;
    step(4'b0011, 4'b0001, 1'b0, 4'b0000, 1'b1);
    step(4'b0011, 4'b0001, 1'b1, 4'b0000, 1'b1);
    step(4'b0011, 4'b0001, 1'b0, 4'b0001, 1'b1);
    step(4'b0011, 4'b0010, 1'b0, 4'b0000, 1'b1);
    step(4'b0011, 4'b0010, 1'b1, 4'b0000, 1'b1);
    step(4'b0011, 4'b0010, 1'b0, 4'b0010, 1'b1);
    step(4'b0011, 4'b0001, 1'b0, 4'b0000, 1'b1);
    step(4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b1);
    step(4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1);
    step(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
